// File: rtl/pwm_multi_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_multi_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int CW_MIN = 2;
  localparam int CW_MAX = 32;
  localparam int CH_MAX = 16;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // LSB of channel ch's duty field inside the packed duty bus.
  function automatic int duty_lsb(input int ch, input int cw);
    return ch * cw;
  endfunction

endpackage

// File: rtl/pwm_multi_ch.sv
// One PWM channel: active duty/polarity registers and the registered comparator output.
module pwm_multi_ch
  import pwm_multi_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] cnt,
  input  logic          load,
  input  logic [CW-1:0] stg_duty,
  input  logic          stg_polarity,
  input  logic          enable,
  output logic          pwm_o
);

  logic [CW-1:0] duty_act;
  logic          pol_act;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_act <= '0;
      pol_act  <= 1'b0;
      pwm_o    <= 1'b0;
    end else begin
      if (load) begin
        duty_act <= stg_duty;
        pol_act  <= stg_polarity;
      end
      // Output reflects the current cnt with the currently active settings.
      pwm_o <= enable ? ((cnt < duty_act) ^ pol_act) : pol_act;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter with double-buffered
// period/duty/mode/polarity that only take effect at a period boundary or while idle.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic             center,
  input  logic [CH-1:0]    polarity,
  input  logic             update,
  output logic             busy,
  output logic             period_tick,
  output logic [CH-1:0]    pwm_o
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             en_q;
  logic             run;
  logic             boundary;
  logic             load;

  logic [CW-1:0]    stg_period;
  logic [CH*CW-1:0] stg_duty;
  logic             stg_center;
  logic [CH-1:0]    stg_polarity;
  logic [CW-1:0]    act_period;
  logic             act_center;

  // The counter only advances once enable has been high for a full cycle, so the
  // first enabled cycle presents cnt=0 and the first period_tick lands one later.
  assign run      = enable & en_q;
  assign boundary = run && (cnt_d == '0);
  // A strobe in the same cycle as a boundary keeps staging pending.
  assign load     = busy && !update && (boundary || !run);

  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (run && (act_period != '0)) begin
      if (act_center == MODE_EDGE) begin
        cnt_d = (cnt_q >= act_period) ? '0 : cnt_q + CNT_ONE;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= act_period) begin
          cnt_d = cnt_q - CNT_ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
        dir_d = DIR_DOWN;
      end
      if (cnt_d == '0) dir_d = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      en_q         <= 1'b0;
      period_tick  <= 1'b0;
      busy         <= 1'b0;
      stg_period   <= '0;
      stg_duty     <= '0;
      stg_center   <= MODE_EDGE;
      stg_polarity <= '0;
      act_period   <= '0;
      act_center   <= MODE_EDGE;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      en_q        <= enable;
      period_tick <= run && (cnt_q == '0);
      if (update) begin
        stg_period   <= period;
        stg_duty     <= duty;
        stg_center   <= center;
        stg_polarity <= polarity;
        busy         <= 1'b1;
      end else if (load) begin
        busy <= 1'b0;
      end
      if (load) begin
        act_period <= stg_period;
        act_center <= stg_center;
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_multi_ch #(.CW(CW)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .cnt          (cnt_q),
      .load         (load),
      .stg_duty     (stg_duty[duty_lsb(i, CW) +: CW]),
      .stg_polarity (stg_polarity[i]),
      .enable       (run),
      .pwm_o        (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi; each expected word is {busy, period_tick, pwm_o[3:0]}.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic             center;
  logic [CH-1:0]    polarity;
  logic             update;
  logic             busy;
  logic             period_tick;
  logic [CH-1:0]    pwm_o;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  string      tag;
  int         checks   = 0;
  int         failures = 0;
  int         cyc_n    = 0;

  pwm_multi #(.CH(CH), .CW(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .duty        (duty),
    .center      (center),
    .polarity    (polarity),
    .update      (update),
    .busy        (busy),
    .period_tick (period_tick),
    .pwm_o       (pwm_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs are set before the edge, the expected outputs after that
  // edge are queued at the edge, and the update strobe is dropped afterwards.
  task automatic cyc(input logic [5:0] e);
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    update = 1'b0;
  endtask

  task automatic cfg(input logic [CW-1:0] p, input logic [CW-1:0] d3, input logic [CW-1:0] d2,
                     input logic [CW-1:0] d1, input logic [CW-1:0] d0, input logic c,
                     input logic [CH-1:0] pol);
    period   = p;
    duty     = {d3, d2, d1, d0};
    center   = c;
    polarity = pol;
    update   = 1'b1;
  endtask

  // Scoreboard monitor: one DUT output word per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] a;
    string      t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {busy, period_tick, pwm_o};
      cyc_n++;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: got busy,tick,pwm=%b required %b", t, cyc_n, a, e);
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; update = 1'b0;
    period = '0; duty = '0; center = 1'b0; polarity = '0;

    tag = "reset";
    cyc(6'b00_0000); cyc(6'b00_0000);

    // Edge mode P=4, D={3,0,5,2}
    tag = "edge_p4";
    reset_n = 1'b1;
    cfg(16'd4, 16'd3, 16'd0, 16'd5, 16'd2, 1'b0, 4'b0000);
    cyc(6'b10_0000);
    cyc(6'b00_0000);
    enable = 1'b1;
    cyc(6'b00_0000);
    for (int r = 0; r < 3; r++) begin
      cyc(6'b01_1011); cyc(6'b00_1011); cyc(6'b00_1010); cyc(6'b00_0010); cyc(6'b00_0010);
    end

    // Center mode P=3, D={1,0,4,2}
    tag = "center_p3";
    enable = 1'b0;
    cfg(16'd3, 16'd1, 16'd0, 16'd4, 16'd2, 1'b1, 4'b0000);
    cyc(6'b10_0000);
    enable = 1'b1;
    cyc(6'b00_0000);
    for (int r = 0; r < 2; r++) begin
      cyc(6'b01_1011); cyc(6'b00_0011); cyc(6'b00_0010);
      cyc(6'b00_0010); cyc(6'b00_0010); cyc(6'b00_0011);
    end

    // Mid-period update: P=9 D0=5, strobe P=4 D0=1 at cnt=3
    tag = "mid_update";
    enable = 1'b0;
    cfg(16'd9, 16'd0, 16'd0, 16'd10, 16'd5, 1'b0, 4'b0000);
    cyc(6'b10_0000);
    enable = 1'b1;
    cyc(6'b00_0000);
    cyc(6'b01_0011); cyc(6'b00_0011); cyc(6'b00_0011);
    cfg(16'd4, 16'd0, 16'd0, 16'd5, 16'd1, 1'b0, 4'b0000);
    cyc(6'b10_0011); cyc(6'b10_0011);
    for (int k = 0; k < 4; k++) cyc(6'b10_0010);
    cyc(6'b00_0010);
    for (int r = 0; r < 2; r++) begin
      cyc(6'b01_0011);
      for (int k = 0; k < 4; k++) cyc(6'b00_0010);
    end

    // Strobes coincident with two successive boundaries: only the second applies
    tag = "boundary_upd";
    cyc(6'b01_0011);
    for (int k = 0; k < 3; k++) cyc(6'b00_0010);
    cfg(16'd2, 16'd0, 16'd0, 16'd0, 16'd2, 1'b0, 4'b0000);
    cyc(6'b10_0010);
    cyc(6'b11_0011);
    for (int k = 0; k < 3; k++) cyc(6'b10_0010);
    cfg(16'd3, 16'd0, 16'd0, 16'd1, 16'd3, 1'b0, 4'b0000);
    cyc(6'b10_0010);
    cyc(6'b11_0011);
    for (int k = 0; k < 3; k++) cyc(6'b10_0010);
    cyc(6'b00_0010);
    for (int r = 0; r < 2; r++) begin
      cyc(6'b01_0011); cyc(6'b00_0001); cyc(6'b00_0001); cyc(6'b00_0000);
    end

    // Polarity on channel 0, then enable dropped mid-period and restored
    tag = "pol_enable";
    cfg(16'd3, 16'd0, 16'd0, 16'd1, 16'd3, 1'b0, 4'b0001);
    cyc(6'b11_0011); cyc(6'b10_0001); cyc(6'b10_0001); cyc(6'b00_0000);
    cyc(6'b01_0010); cyc(6'b00_0000);
    enable = 1'b0;
    cyc(6'b00_0001); cyc(6'b00_0001);
    enable = 1'b1;
    cyc(6'b00_0001);
    cyc(6'b01_0010); cyc(6'b00_0000); cyc(6'b00_0000); cyc(6'b00_0001);

    // Reset while an update is pending, then P=0 and a strobe on a P=0 boundary
    tag = "reset_busy";
    cfg(16'd7, 16'd0, 16'd0, 16'd0, 16'd7, 1'b0, 4'b0000);
    cyc(6'b11_0010);
    reset_n = 1'b0;
    cyc(6'b00_0000);
    reset_n = 1'b1;
    cyc(6'b00_0000);
    tag = "p_zero";
    cyc(6'b01_0000); cyc(6'b01_0000); cyc(6'b01_0000);
    cfg(16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 1'b0, 4'b0000);
    cyc(6'b11_0000);
    cyc(6'b01_0000);
    cyc(6'b01_0001); cyc(6'b00_0000); cyc(6'b01_0001); cyc(6'b00_0000);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
